// File: rtl/shift_io_pkg.sv
// Shared types and defaults for the shift-register I/O scanner.
package shift_io_pkg;

  localparam int unsigned DEFAULT_WIDTH   = 8;
  localparam int unsigned DEFAULT_CLK_DIV = 4;

  // Scan frame sequence: LOAD -> SETTLE -> SHIFT -> DONE, entered from IDLE.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_SHIFT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/shift_tick_gen.sv
// Phase timer: pulses tick_o on the last clk cycle of every CLK_DIV-cycle
// phase. restart_i realigns the phase so each FSM state starts a fresh count.
module shift_tick_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart_i,
  output logic tick_o
);

  logic [7:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == 8'(CLK_DIV - 1));

  // Next count: wrap at phase end or when the FSM changes state.
  always_comb begin
    cnt_d = cnt_q + 8'd1;
    if (restart_i || tick_o) cnt_d = '0;
  end

  // Phase counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/shift_io_scanner.sv
// Drives a parallel-in (DIP) and a serial-in (LED) shift-register chain that
// share one latch line and one shift clock. Every output is a flop whose next
// value is derived from the next FSM state, so outputs are glitch-free.
module shift_io_scanner
  import shift_io_pkg::*;
#(
  parameter int unsigned WIDTH   = DEFAULT_WIDTH,
  parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             scan_en,
  input  logic [WIDTH-1:0] led_data,
  input  logic             led_valid,
  output logic             led_ready,
  output logic [WIDTH-1:0] dip_data,
  output logic             dip_valid,
  output logic             sr_latch,
  output logic             sr_clk,
  output logic             sr_dout,
  input  logic             sr_din
);

  localparam int unsigned   BW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] led_q, led_d;
  logic [WIDTH-1:0] dip_q, dip_d;
  logic [WIDTH-1:0] dip_data_q, dip_data_d;
  logic             sr_latch_q, sr_latch_d;
  logic             sr_clk_q, sr_clk_d;
  logic             sr_dout_q, sr_dout_d;
  logic             dip_valid_q, dip_valid_d;
  logic             led_ready_q, led_ready_d;

  logic tick;
  logic restart;
  logic handshake;
  logic hi_end;     // last cycle of an sr_clk-high phase
  logic lo_end;     // last cycle of an sr_clk-low phase (DIP sample point)
  logic last_bit;
  logic shift_out;  // present the next LED bit on sr_dout
  logic load_entry;

  shift_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart_i(restart),
    .tick_o   (tick)
  );

  assign restart    = (state_d != state_q);
  assign handshake  = led_valid && led_ready_q;
  assign hi_end     = (state_q == ST_SHIFT) && tick && sr_clk_q;
  assign lo_end     = (state_q == ST_SHIFT) && tick && !sr_clk_q;
  assign last_bit   = (bit_q == LAST_BIT);
  assign load_entry = (state_d == ST_LOAD) && (state_q != ST_LOAD);
  assign shift_out  = ((state_q == ST_SETTLE) && (state_d == ST_SHIFT)) ||
                      (hi_end && !last_bit);

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; a started frame always runs through DONE.
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (scan_en)             state_d = ST_LOAD;
      ST_LOAD:   if (tick)                state_d = ST_SETTLE;
      ST_SETTLE: if (tick)                state_d = ST_SHIFT;
      ST_SHIFT:  if (hi_end && last_bit)  state_d = ST_DONE;
      ST_DONE:   state_d = scan_en ? ST_LOAD : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, decoded from the next state.
  always_comb begin
    sr_latch_d  = (state_d != ST_LOAD);
    led_ready_d = (state_d != ST_SHIFT);
    dip_valid_d = (state_d == ST_DONE);
    dip_data_d  = dip_valid_d ? dip_q : dip_data_q;
    sr_clk_d    = 1'b0;
    if ((state_q == ST_SHIFT) && (state_d == ST_SHIFT))
      sr_clk_d = tick ? ~sr_clk_q : sr_clk_q;
    // sr_dout only moves together with a falling (or still-low) sr_clk.
    sr_dout_d = sr_dout_q;
    if (shift_out) sr_dout_d = led_q[WIDTH-1];
  end

  // Bit counter, shadow register and the two shift registers.
  always_comb begin
    bit_d = bit_q;
    if (restart)                 bit_d = '0;
    else if (hi_end && !last_bit) bit_d = bit_q + BW'(1);

    shadow_d = handshake ? led_data : shadow_q;

    // A handshake coinciding with LOAD entry bypasses the shadow.
    led_d = led_q;
    if (load_entry)     led_d = handshake ? led_data : shadow_q;
    else if (shift_out) led_d = led_q << 1;

    dip_d = dip_q;
    if (lo_end) dip_d = (dip_q << 1) | WIDTH'(sr_din);
  end

  // Datapath and output registers.
  // NOTE: every register here, including the shift chains, is reset so an
  // abandoned frame can leave no stale bits behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_q       <= '0;
      shadow_q    <= '0;
      led_q       <= '0;
      dip_q       <= '0;
      dip_data_q  <= '0;
      sr_latch_q  <= 1'b1;
      sr_clk_q    <= 1'b0;
      sr_dout_q   <= 1'b0;
      dip_valid_q <= 1'b0;
      led_ready_q <= 1'b1;
    end else begin
      bit_q       <= bit_d;
      shadow_q    <= shadow_d;
      led_q       <= led_d;
      dip_q       <= dip_d;
      dip_data_q  <= dip_data_d;
      sr_latch_q  <= sr_latch_d;
      sr_clk_q    <= sr_clk_d;
      sr_dout_q   <= sr_dout_d;
      dip_valid_q <= dip_valid_d;
      led_ready_q <= led_ready_d;
    end
  end

  assign led_ready = led_ready_q;
  assign dip_data  = dip_data_q;
  assign dip_valid = dip_valid_q;
  assign sr_latch  = sr_latch_q;
  assign sr_clk    = sr_clk_q;
  assign sr_dout   = sr_dout_q;

endmodule

// File: tb/tb_shift_io_scanner.sv
// Bench for shift_io_scanner: external 165/595 chain models, a frame-position
// reference model, per-cycle comparison, directed scenarios, random traffic.
module tb_shift_io_scanner;

  localparam int W = 8;
  localparam int C = 4;
  localparam int L = 2*C + 2*C*W + 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         scan_en = 1'b0;
  logic         led_valid = 1'b0;
  logic [W-1:0] led_data = '0;
  logic         led_ready;
  logic [W-1:0] dip_data;
  logic         dip_valid;
  logic         sr_latch;
  logic         sr_clk;
  logic         sr_dout;
  logic         sr_din;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  shift_io_scanner #(.WIDTH(W), .CLK_DIV(C)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .scan_en  (scan_en),
    .led_data (led_data),
    .led_valid(led_valid),
    .led_ready(led_ready),
    .dip_data (dip_data),
    .dip_valid(dip_valid),
    .sr_latch (sr_latch),
    .sr_clk   (sr_clk),
    .sr_dout  (sr_dout),
    .sr_din   (sr_din)
  );

  // ---------------- external chains ----------------
  logic [W-1:0] dip_pat = 8'hA5;
  logic [W-1:0] dip_chain = '0;
  logic [W-1:0] led_chain = '0;
  logic [W-1:0] led_out = '0;
  logic [W-1:0] disp_q[$];

  // DIP chain: parallel load while latch low, shift toward QH on sr_clk rise.
  always @(posedge sr_clk or negedge sr_latch)
    if (!sr_latch) dip_chain <= dip_pat;
    else           dip_chain <= dip_chain << 1;
  assign sr_din = dip_chain[W-1];

  // LED chain: shift on sr_clk rise, storage register on latch rise.
  always @(posedge sr_clk) led_chain <= {led_chain[W-2:0], sr_dout};
  always @(posedge sr_latch) led_out <= led_chain;
  always @(posedge sr_latch) if (rst_n) disp_q.push_back(led_chain);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit           m_active, m_known, m_hs;
  int           m_p;
  logic [W-1:0] m_shadow, m_cur, m_chain, m_dip, m_pat, m_next;

  wire in_load   = m_active && (m_p < C);
  wire in_shift  = m_active && (m_p >= 2*C) && (m_p < L-1);
  wire exp_ready = !in_shift;
  wire exp_clk   = in_shift && ((((m_p - 2*C) / C) % 2) == 1);
  wire exp_dv    = m_active && (m_p == L-1);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 0; m_known <= 0; m_p <= 0;
      m_shadow <= '0; m_cur <= '0; m_chain <= '0; m_dip <= '0; m_pat <= '0;
    end else begin
      m_hs   = led_valid && exp_ready;
      m_next = m_hs ? led_data : m_shadow;
      if (m_hs) m_shadow <= led_data;
      if (!m_active) begin
        if (scan_en) begin m_active <= 1; m_p <= 0; m_cur <= m_next; m_pat <= dip_pat; end
      end else if (m_p == L-1) begin
        if (scan_en) begin m_p <= 0; m_cur <= m_next; m_pat <= dip_pat; end
        else m_active <= 0;
      end else begin
        m_p <= m_p + 1;
        if (m_p == L-2) begin m_dip <= m_pat; m_chain <= m_cur; m_known <= 1; end
      end
    end
  end

  // Per-cycle comparison against the model.
  logic prev_dout = 1'b0;
  always @(negedge clk) begin
    check("sr_latch", sr_latch, !in_load);
    check("sr_clk", sr_clk, exp_clk);
    check("led_ready", led_ready, exp_ready);
    check("dip_valid", dip_valid, exp_dv);
    check("dip_data", dip_data, m_dip);
    if (sr_dout !== prev_dout) check("dout_moves_while_clk_low", sr_clk, 0);
    prev_dout = sr_dout;
    if (m_active && (m_p == C) && m_known) check("led_display", led_out, m_chain);
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_dv(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (dip_valid) begin ok = 1; break; end
    end
  endtask

  task automatic wait_disp(input int n, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (disp_q.size() >= n) begin ok = 1; break; end
      step();
    end
  endtask

  task automatic wait_rises(input int n, input int budget, output int rises);
    logic prevc;
    rises = 0;
    prevc = sr_clk;
    for (int i = 0; i < budget; i++) begin
      step();
      if (sr_clk && !prevc) rises++;
      prevc = sr_clk;
      if (rises == n) break;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_latch"}, sr_latch, 1);
    check({tag, "_clk"}, sr_clk, 0);
    check({tag, "_dout"}, sr_dout, 0);
    check({tag, "_dip_data"}, dip_data, 0);
    check({tag, "_dip_valid"}, dip_valid, 0);
    check({tag, "_ready"}, led_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    bit ok;
    int first_low, low_cnt, dv_cyc, rises, cnt, dv_rand;

    repeat (3) step();
    @(negedge clk);
    check_reset_outputs("reset");
    step(); rst_n = 1'b1; step(); step();

    // LED pattern offered while idle, then start scanning.
    led_valid = 1'b1; led_data = 8'h3C; step();
    led_valid = 1'b0; step();
    scan_en = 1'b1;

    first_low = -1; low_cnt = 0; dv_cyc = -1;
    for (int cyc = 0; cyc < 200 && dv_cyc < 0; cyc++) begin
      @(negedge clk);
      if (!sr_latch) begin
        low_cnt++;
        if (first_low < 0) first_low = cyc;
      end
      if (dip_valid) dv_cyc = cyc;
    end
    check("frame1_dv_cycle", dv_cyc - first_low + 1, 73);
    check("latch_low_cycles", low_cnt, 4);
    check("frame1_dip", dip_data, 8'hA5);
    dip_pat = 8'h5A;
    step();

    // Frame 2 latch rise must show 3C; frame 1 showed the reset chain.
    wait_disp(2, 200, ok);
    check("frame2_latch_seen", ok, 1);
    if (disp_q.size() >= 2) begin
      check("frame1_display", disp_q[0], 8'h00);
      check("frame2_display", disp_q[1], 8'h3C);
    end
    // Two handshakes in one frame: the later one wins.
    led_valid = 1'b1; led_data = 8'h11; step();
    led_data = 8'h22; step();
    led_valid = 1'b0;

    wait_dv(200, ok); check("frame2_done", ok, 1);
    check("frame2_dip", dip_data, 8'h5A);
    step();
    wait_dv(200, ok); check("frame3_done", ok, 1);
    // Handshake in the DONE cycle is taken straight into the LED register.
    led_valid = 1'b1; led_data = 8'h7E;
    @(posedge clk); #1;
    led_valid = 1'b0;

    wait_disp(5, 400, ok);
    check("frame5_latch_seen", ok, 1);
    if (disp_q.size() >= 5) begin
      check("frame3_display", disp_q[2], 8'h3C);
      check("frame4_display", disp_q[3], 8'h22);
      check("frame5_display", disp_q[4], 8'h7E);
    end

    // Drop scan_en during bit 3 of SHIFT: frame still completes.
    wait_rises(4, 200, rises);
    check("reach_bit3", rises, 4);
    scan_en = 1'b0;
    wait_dv(200, ok); check("dv_after_drop", ok, 1);
    cnt = 0; dv_cyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sr_latch) cnt++;
      if (dip_valid) dv_cyc++;
    end
    check("idle_latch_high", cnt, 20);
    check("idle_no_dv", dv_cyc, 0);

    // Reset during bit 5 of SHIFT abandons the frame.
    step();
    scan_en = 1'b1;
    dip_pat = 8'hC3;
    wait_rises(6, 300, rises);
    check("reach_bit5", rises, 6);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midshift_reset");
    scan_en = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 2*L; i++) begin
      @(negedge clk);
      if (dip_valid) cnt++;
    end
    check("no_dv_after_abort", cnt, 0);
    check("dip_cleared_after_abort", dip_data, 0);

    // Random traffic checked by the model.
    step();
    scan_en = 1'b1;
    dv_rand = 0;
    for (int i = 0; i < 4000; i++) begin
      step();
      if (dip_valid) dv_rand++;
      led_valid = ($urandom_range(3) == 0);
      led_data  = W'($urandom);
      dip_pat   = W'($urandom);
      if ($urandom_range(99) == 0) scan_en = ~scan_en;
      if (i == 2000) rst_n = 1'b0;
      if (i == 2002) rst_n = 1'b1;
    end
    check("random_frames_seen", (dv_rand > 10), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_io_scanner.md
SHIFT_IO_SCANNER -- requirements
Module: shift_io_scanner

Interface
REQ-001 Parameter WIDTH, default 8, number of bits in each external shift-register chain (DIP input chain and LED output chain).
REQ-002 Parameter CLK_DIV, default 4, length of each sr_clk phase and each latch phase, in clk cycles; legal range 1..255.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 scan_en  input  1  level; when high, frames repeat back-to-back.
REQ-006 led_data  input  WIDTH  LED pattern offered by the requester.
REQ-007 led_valid  input  1  led_data is valid.
REQ-008 led_ready  output  1  shadow register can accept led_data.
REQ-009 dip_data  output  WIDTH  last complete DIP sample.
REQ-010 dip_valid  output  1  one-cycle pulse when dip_data updates.
REQ-011 sr_latch  output  1  shared latch line: low = parallel-load DIP chain; rising edge = transfer LED chain to its outputs.
REQ-012 sr_clk  output  1  shift clock to both chains.
REQ-013 sr_dout  output  1  serial data to the LED chain.
REQ-014 sr_din  input  1  serial data from the DIP chain.

Function
REQ-015 The block SHALL implement the FSM IDLE -> LOAD -> SETTLE -> SHIFT -> DONE -> (LOAD if scan_en, else IDLE); IDLE -> LOAD when scan_en=1.
REQ-016 In IDLE: sr_latch=1, sr_clk=0, sr_dout held.
REQ-017 In LOAD: sr_latch=0 for exactly CLK_DIV cycles, sr_clk=0.
REQ-018 On LOAD entry, the LED shift register SHALL load from the shadow register; if a led_valid&&led_ready handshake occurs in the same cycle, the new led_data SHALL be used (bypass).
REQ-019 In SETTLE: sr_latch=1 for CLK_DIV cycles, sr_clk=0. The latch rising edge displays the LED data shifted in the previous frame (one-frame LED latency).
REQ-020 In SHIFT: WIDTH bit periods, each with sr_clk=0 for CLK_DIV cycles followed by sr_clk=1 for CLK_DIV cycles.
REQ-021 sr_dout SHALL change only while sr_clk=0. It SHALL present the LED register MSB first.
REQ-022 sr_din SHALL be sampled in the last clk cycle of each sr_clk-low phase and shifted into the DIP register at the LSB, so the first bit received ends in dip_data[WIDTH-1].
REQ-023 In DONE (1 cycle): dip_data <= DIP register; dip_valid=1 for exactly this cycle; sr_clk=0.
REQ-024 Frame length SHALL be 2*CLK_DIV + 2*CLK_DIV*WIDTH + 1 cycles (73 at defaults).
REQ-025 led_ready SHALL be 1 in every state except SHIFT. A handshake writes the shadow register. A later handshake before the next LOAD overwrites it (last value wins).
REQ-026 scan_en deasserted mid-frame SHALL NOT abort the frame; the FSM enters IDLE after DONE.
REQ-027 Bit counter and phase counter SHALL wrap only on FSM transitions; no output glitch at state boundaries. All outputs are registered.

Reset
REQ-028 While rst_n=0, asynchronously: state=IDLE, sr_latch=1, sr_clk=0, sr_dout=0, dip_data=0, dip_valid=0, shadow=0, LED and DIP registers=0, counters=0, led_ready=1.
REQ-029 Reset asserted mid-SHIFT SHALL abandon the frame: no dip_valid and no partial dip_data update. The first frame after release starts from IDLE.

Structure
REQ-030 Package shift_io_pkg SHALL hold the FSM state enum and the default WIDTH/CLK_DIV constants.
REQ-031 One sub-module, shift_tick_gen, SHALL produce the CLK_DIV phase-end tick. It is restarted on every FSM transition.
REQ-032 The top level SHALL contain the FSM, the bit counter, the shadow register, and the two shift registers.

Verification
REQ-033 Reset; scan_en=1; bench DIP model holds 8'hA5 -> dip_valid at cycle 73 of frame 1, dip_data=8'hA5; sr_latch low for exactly 4 cycles per frame.
REQ-034 Handshake led_data=8'h3C in IDLE, then scan_en=1 -> bench 595 model shows 8'h3C on its outputs at the sr_latch rising edge of frame 2, not frame 1.
REQ-035 Handshakes 8'h11 then 8'h22 within one frame -> next LOAD uses 8'h22; led_ready=0 throughout every SHIFT.
REQ-036 Handshake 8'h7E in the DONE->LOAD transition cycle -> LED register loads 8'h7E (bypass).
REQ-037 scan_en dropped at bit 3 of SHIFT -> frame completes with dip_valid=1, then IDLE with sr_latch=1 held.
REQ-038 rst_n pulsed low at bit 5 of SHIFT -> all outputs at reset values immediately; no dip_valid in that frame.
